corebus_request_arbiter: RTL and testbench

Round-robin N:1 arbiter that shares a single corebus slave port among `MASTERS` corebus requesters.
- Command channel: arbitrated, with the grant held until the command is accepted.
- Write-data channel: locked to the owner of the most recent write command until its last beat is accepted.
- ID tagging: the winner's index is prepended to the outgoing ID.
- Response channel: routed back to the requester named by the upper ID bits.

The block sits between the per-core request ports and the shared memory/fabric corebus target.

---
 rtl/corebus_request_arbiter.sv | 105 ++++++++++
 tb/tb_corebus_request_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/corebus_request_arbiter.sv
// corebus_request_arbiter: round-robin N:1 corebus arbiter with write-data lock and ID-routed responses.
module corebus_request_arbiter #(
  parameter int MASTERS = 4,
  parameter int ID_W    = 8,
  parameter int ADDR_W  = 32,
  parameter int LEN_W   = 8,
  parameter int DATA_W  = 64,
  localparam int SEL_W  = (MASTERS > 1) ? $clog2(MASTERS) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [MASTERS-1:0]       i_mcmd_valid,
  output logic [MASTERS-1:0]       o_scmd_accept,
  input  logic [2:0]               i_mcmd [MASTERS],
  input  logic [ID_W-1:0]          i_mid [MASTERS],
  input  logic [ADDR_W-1:0]        i_maddr [MASTERS],
  input  logic [LEN_W-1:0]         i_mlength [MASTERS],
  input  logic [MASTERS-1:0]       i_mdata_valid,
  output logic [MASTERS-1:0]       o_sdata_accept,
  input  logic [DATA_W-1:0]        i_mdata [MASTERS],
  input  logic [DATA_W/8-1:0]      i_mdata_byteen [MASTERS],
  input  logic [MASTERS-1:0]       i_mdata_last,
  output logic [MASTERS-1:0]       o_sresp_valid,
  input  logic [MASTERS-1:0]       i_mresp_accept,
  output logic [ID_W-1:0]          o_sid [MASTERS],
  output logic [MASTERS-1:0]       o_serror,
  output logic [DATA_W-1:0]        o_sdata [MASTERS],
  output logic [MASTERS-1:0]       o_sresp_last,
  output logic                     o_mcmd_valid,
  input  logic                     i_scmd_accept,
  output logic [2:0]               o_mcmd,
  output logic [ADDR_W-1:0]        o_maddr,
  output logic [LEN_W-1:0]         o_mlength,
  output logic [SEL_W+ID_W-1:0]    o_mid,
  output logic                     o_mdata_valid,
  input  logic                     i_sdata_accept,
  output logic [DATA_W-1:0]        o_mdata,
  output logic [DATA_W/8-1:0]      o_mdata_byteen,
  output logic                     o_mdata_last,
  input  logic                     i_sresp_valid,
  output logic                     o_mresp_accept,
  input  logic [SEL_W+ID_W-1:0]    i_sid,
  input  logic                     i_serror,
  input  logic [DATA_W-1:0]        i_sdata,
  input  logic                     i_sresp_last,
  output logic                     o_route_error
);
  logic [SEL_W-1:0] rr_q, rr_d, hold_idx_q, lock_idx_q, pick, cand, win, own, ridx;
  logic hold_q, hold_d, lock_q, lock_d, route_q, found;
  logic cmd_v, cmd_hs, own_v, last_hs, rok;
  always_comb begin
    pick = rr_q;
    found = 1'b0;
    cand = '0;
    for (int i = 0; i < MASTERS; i++) begin
      cand = SEL_W'((int'(rr_q) + i) % MASTERS);
      if (!found && i_mcmd_valid[cand]) begin
        pick = cand;
        found = 1'b1;
      end
    end
  end
  // A held grant overrides the round-robin search so the command stays stable until accepted.
  assign win     = hold_q ? hold_idx_q : pick;
  assign cmd_v   = i_mcmd_valid[win] && !lock_q;
  assign cmd_hs  = cmd_v && i_scmd_accept;
  assign own_v   = lock_q || (cmd_v && i_mcmd[win][0]);
  assign own     = lock_q ? lock_idx_q : win;
  assign last_hs = o_mdata_valid && i_sdata_accept && o_mdata_last;
  assign o_mcmd_valid   = cmd_v;
  assign o_mcmd         = i_mcmd[win];
  assign o_maddr        = i_maddr[win];
  assign o_mlength      = i_mlength[win];
  assign o_mid          = {win, i_mid[win]};
  assign o_mdata_valid  = own_v && i_mdata_valid[own];
  assign o_mdata        = i_mdata[own];
  assign o_mdata_byteen = i_mdata_byteen[own];
  assign o_mdata_last   = i_mdata_last[own];
  assign ridx           = i_sid[SEL_W+ID_W-1:ID_W];
  assign rok            = int'(ridx) < MASTERS;
  assign o_mresp_accept = rok ? i_mresp_accept[ridx] : 1'b1;
  assign o_route_error  = route_q;
  always_comb begin
    for (int k = 0; k < MASTERS; k++) begin
      o_scmd_accept[k]  = cmd_hs && win == SEL_W'(k);
      o_sdata_accept[k] = own_v && i_sdata_accept && own == SEL_W'(k);
      o_sresp_valid[k]  = i_sresp_valid && rok && ridx == SEL_W'(k);
      o_sid[k]          = i_sid[ID_W-1:0];
      o_serror[k]       = i_serror;
      o_sdata[k]        = i_sdata;
      o_sresp_last[k]   = i_sresp_last;
    end
  end
  assign hold_d = cmd_v && !i_scmd_accept;
  assign rr_d   = cmd_hs ? ((int'(win) == MASTERS - 1) ? '0 : win + 1'b1) : rr_q;
  assign lock_d = (lock_q || (cmd_hs && i_mcmd[win][0])) && !last_hs;
  always_ff @(posedge i_clk) begin
    rr_q       <= i_rst ? '0 : rr_d;
    hold_q     <= i_rst ? 1'b0 : hold_d;
    lock_q     <= i_rst ? 1'b0 : lock_d;
    route_q    <= i_rst ? 1'b0 : route_q || (i_sresp_valid && !rok);
    hold_idx_q <= win;
    lock_idx_q <= cmd_hs ? win : lock_idx_q;
  end
endmodule

// File: tb/tb_corebus_request_arbiter.sv
// tb_corebus_request_arbiter: directed checks of arbitration, write lock, response routing and reset.
module tb_corebus_request_arbiter;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  int total = 0, bad = 0;

  logic [3:0] mv = 0, mdv = 0, mlast = 0, macc = 0;
  logic [2:0] mcmd [4];
  logic [7:0] mid [4], mlen [4], mbe [4];
  logic [31:0] maddr [4];
  logic [63:0] mdata [4];
  logic [3:0] scmd_acc, sdata_acc, sresp_v, serr, slast;
  logic [7:0] sid [4];
  logic [63:0] sdat [4];
  logic cv, scmd_a = 0, dv, sdata_a = 0, sresp_in = 0, serr_in = 0, slast_in = 0, racc, rerr, dlast;
  logic [2:0] ocmd;
  logic [31:0] oaddr;
  logic [7:0] olen, obe;
  logic [9:0] omid, sid_in = 0;
  logic [63:0] odata, sdat_in = 0;

  logic [2:0] mv3 = 0, mdv3 = 0, mlast3 = 0, macc3 = 0;
  logic [2:0] mcmd3 [3];
  logic [7:0] mid3 [3], mlen3 [3], mbe3 [3];
  logic [31:0] maddr3 [3];
  logic [63:0] mdata3 [3];
  logic [2:0] scmd_acc3, sdata_acc3, sresp_v3, serr3, slast3;
  logic [7:0] sid3 [3];
  logic [63:0] sdat3 [3];
  logic cv3, scmd_a3 = 0, dv3, sdata_a3 = 0, sresp_in3 = 0, racc3, rerr3, dlast3;
  logic [2:0] ocmd3;
  logic [31:0] oaddr3;
  logic [7:0] olen3, obe3;
  logic [9:0] omid3, sid_in3 = 0;
  logic [63:0] odata3;

  corebus_request_arbiter u4 (
    .i_clk(clk), .i_rst(rst), .i_mcmd_valid(mv), .o_scmd_accept(scmd_acc), .i_mcmd(mcmd),
    .i_mid(mid), .i_maddr(maddr), .i_mlength(mlen), .i_mdata_valid(mdv), .o_sdata_accept(sdata_acc),
    .i_mdata(mdata), .i_mdata_byteen(mbe), .i_mdata_last(mlast), .o_sresp_valid(sresp_v),
    .i_mresp_accept(macc), .o_sid(sid), .o_serror(serr), .o_sdata(sdat), .o_sresp_last(slast),
    .o_mcmd_valid(cv), .i_scmd_accept(scmd_a), .o_mcmd(ocmd), .o_maddr(oaddr), .o_mlength(olen),
    .o_mid(omid), .o_mdata_valid(dv), .i_sdata_accept(sdata_a), .o_mdata(odata), .o_mdata_byteen(obe),
    .o_mdata_last(dlast), .i_sresp_valid(sresp_in), .o_mresp_accept(racc), .i_sid(sid_in),
    .i_serror(serr_in), .i_sdata(sdat_in), .i_sresp_last(slast_in), .o_route_error(rerr));

  corebus_request_arbiter #(.MASTERS(3)) u3 (
    .i_clk(clk), .i_rst(rst), .i_mcmd_valid(mv3), .o_scmd_accept(scmd_acc3), .i_mcmd(mcmd3),
    .i_mid(mid3), .i_maddr(maddr3), .i_mlength(mlen3), .i_mdata_valid(mdv3), .o_sdata_accept(sdata_acc3),
    .i_mdata(mdata3), .i_mdata_byteen(mbe3), .i_mdata_last(mlast3), .o_sresp_valid(sresp_v3),
    .i_mresp_accept(macc3), .o_sid(sid3), .o_serror(serr3), .o_sdata(sdat3), .o_sresp_last(slast3),
    .o_mcmd_valid(cv3), .i_scmd_accept(scmd_a3), .o_mcmd(ocmd3), .o_maddr(oaddr3), .o_mlength(olen3),
    .o_mid(omid3), .o_mdata_valid(dv3), .i_sdata_accept(sdata_a3), .o_mdata(odata3), .o_mdata_byteen(obe3),
    .o_mdata_last(dlast3), .i_sresp_valid(sresp_in3), .o_mresp_accept(racc3), .i_sid(sid_in3),
    .i_serror(1'b0), .i_sdata(64'h0), .i_sresp_last(1'b0), .o_route_error(rerr3));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nx;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < 4; k++) begin
      mcmd[k] = 3'b000; mid[k] = 8'h20 + 8'(k); maddr[k] = 32'h1000 * k; mlen[k] = 0;
      mdata[k] = 64'hA0 + 64'(k); mbe[k] = 8'hFF;
    end
    for (int k = 0; k < 3; k++) begin
      mcmd3[k] = 3'b000; mid3[k] = 8'h30 + 8'(k); maddr3[k] = 0; mlen3[k] = 0;
      mdata3[k] = 64'hC0 + 64'(k); mbe3[k] = 8'hFF;
    end
    nx; nx;
    rst = 0;
    #1;
    chk("rst_cmd_valid", cv, 0);
    chk("rst_scmd_acc", scmd_acc, 0);
    chk("rst_data_valid", dv, 0);
    chk("rst_sdata_acc", sdata_acc, 0);
    chk("rst_resp_valid", sresp_v, 0);
    chk("rst_mresp_acc", racc, 0);
    chk("rst_route_err", rerr, 0);
    // single read from master 0
    mv = 4'b0001; mid[0] = 8'h11; scmd_a = 1;
    #1;
    chk("rd0_valid", cv, 1);
    chk("rd0_mid", omid, 10'h011);
    chk("rd0_acc", scmd_acc, 4'b0001);
    nx;
    mv = 4'b1111;
    #1;
    chk("rd0_rr_next", omid[9:8], 1);
    mv = 0; rst = 1;
    nx;
    rst = 0;
    // continuous reads from all masters
    for (int c = 0; c < 6; c++) begin
      mv = 4'b1111; scmd_a = 1;
      #1;
      chk("rr_grant", omid[9:8], c % 4);
      chk("rr_acc", scmd_acc, 64'(4'b0001 << (c % 4)));
      nx;
    end
    // hold: master 1 stalled, master 0 arrives in cycle 2
    mv = 4'b0010; scmd_a = 0;
    #1;
    chk("hold_c1_idx", omid[9:8], 1);
    chk("hold_c1_acc", scmd_acc, 0);
    nx;
    mv = 4'b0011;
    #1;
    chk("hold_c2_idx", omid[9:8], 1);
    nx;
    #1;
    chk("hold_c3_idx", omid[9:8], 1);
    nx;
    scmd_a = 1;
    #1;
    chk("hold_acc_idx", omid[9:8], 1);
    chk("hold_acc", scmd_acc, 4'b0010);
    nx;
    mv = 4'b0001;
    #1;
    chk("hold_next_idx", omid[9:8], 0);
    chk("hold_next_acc", scmd_acc, 4'b0001);
    nx;
    mv = 0;
    nx;
    // 4-beat write from master 2 with data stall, master 1 read pending
    mv = 4'b0100; mcmd[2] = 3'b001; mlen[2] = 8'd3; mdv = 4'b0100; mdata[2] = 64'hB0; sdata_a = 1;
    #1;
    chk("wr_cmd_idx", omid[9:8], 2);
    chk("wr_len", olen, 3);
    chk("wr_b0_valid", dv, 1);
    chk("wr_b0_data", odata, 64'hB0);
    chk("wr_b0_acc", sdata_acc, 4'b0100);
    nx;
    mv = 4'b0010; mdv = 4'b0110; mdata[1] = 64'hEE; mdata[2] = 64'hB1; sdata_a = 0;
    #1;
    chk("wr_lock_cmd", cv, 0);
    chk("wr_lock_scmd_acc", scmd_acc, 0);
    chk("wr_stall_data", odata, 64'hB1);
    chk("wr_stall_acc", sdata_acc, 0);
    nx;
    #1;
    chk("wr_stall2_cmd", cv, 0);
    nx;
    sdata_a = 1;
    #1;
    chk("wr_b1_acc", sdata_acc, 4'b0100);
    chk("wr_b1_data", odata, 64'hB1);
    nx;
    mdata[2] = 64'hB2;
    #1;
    chk("wr_b2_data", odata, 64'hB2);
    nx;
    mdata[2] = 64'hB3; mlast = 4'b0100;
    #1;
    chk("wr_b3_data", odata, 64'hB3);
    chk("wr_b3_last", dlast, 1);
    chk("wr_b3_cmd", cv, 0);
    nx;
    mdv = 0; mlast = 0; mcmd[2] = 0;
    #1;
    chk("wr_after_idx", omid[9:8], 1);
    chk("wr_after_acc", scmd_acc, 4'b0010);
    chk("wr_after_dv", dv, 0);
    nx;
    // one-beat write: command and last beat together
    mv = 4'b0001; mcmd[0] = 3'b001; mdv = 4'b0001; mlast = 4'b0001; mdata[0] = 64'hD0;
    #1;
    chk("w1_idx", omid[9:8], 0);
    chk("w1_dacc", sdata_acc, 4'b0001);
    chk("w1_last", dlast, 1);
    nx;
    mv = 4'b0010; mdv = 0; mlast = 0; mcmd[0] = 0;
    #1;
    chk("w1_next_valid", cv, 1);
    chk("w1_next_idx", omid[9:8], 1);
    nx;
    mv = 0;
    // response routed to master 3
    sresp_in = 1; sid_in = {2'd3, 8'h5A}; sdat_in = 64'hCAFE; slast_in = 1; macc = 0;
    #1;
    chk("resp_valid", sresp_v, 4'b1000);
    chk("resp_sid", sid[3], 8'h5A);
    chk("resp_data", sdat[3], 64'hCAFE);
    chk("resp_stall", racc, 0);
    nx;
    #1;
    chk("resp_stall2", racc, 0);
    nx;
    macc = 4'b1000;
    #1;
    chk("resp_acc", racc, 1);
    nx;
    sresp_in = 0; macc = 0;
    // out-of-range index on the 3-master instance
    sresp_in3 = 1; sid_in3 = {2'd3, 8'h77};
    #1;
    chk("route_valid", sresp_v3, 0);
    chk("route_drop_acc", racc3, 1);
    nx;
    sresp_in3 = 0; sid_in3 = 0;
    #1;
    chk("route_err_set", rerr3, 1);
    chk("route_err_u4", rerr, 0);
    nx;
    #1;
    chk("route_err_hold", rerr3, 1);
    mv3 = 3'b001; mcmd3[0] = 3'b001; mlen3[0] = 8'd1; mdv3 = 3'b001; scmd_a3 = 1; sdata_a3 = 1;
    nx;
    mv3 = 0;
    #1;
    chk("u3_locked_dv", dv3, 1);
    chk("u3_locked_dacc", sdata_acc3, 3'b001);
    rst = 1;
    nx;
    rst = 0;
    #1;
    chk("u3_rst_dv", dv3, 0);
    chk("u3_rst_dacc", sdata_acc3, 0);
    chk("u3_rst_cv", cv3, 0);
    chk("u3_rst_cacc", scmd_acc3, 0);
    chk("u3_rst_rv", sresp_v3, 0);
    chk("u3_rst_racc", racc3, 0);
    chk("u3_rst_err", rerr3, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
